// File: rtl/spi_pkg.sv
// Shared SPI definitions for the Simple SPI link. The master and the slave both use
// the mode encodings, the state type and the default underrun word.
package spi_pkg;

    // Mode number = {CPOL, CPHA}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int          MAX_DATA_WIDTH    = 64;
    localparam logic [63:0] UNDERRUN_ALL_ONES = '1;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for one asynchronous input. The reset value is chosen per
// instance, so that no false edge appears when reset is released.
module sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave. SCLK, CS and MOSI are sampled in the clk domain. The block
// deserialises MOSI into words and shifts the buffered transmit word out on MISO.
//
// Transmit handshake: a word is taken when tx_valid && tx_ready, and tx_ready is
// !buffer_full. A word offered during the same cycle that the buffer drains into the
// shift register is also taken, so that tx_ready does not rise between the two words.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic                  CPOL          = 1'b0,
    parameter logic                  CPHA          = 1'b0,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = UNDERRUN_ALL_ONES[DATA_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic sclk_s, cs_s, mosi_s, sclk_q;
    logic sclk_change, lead_edge, trail_edge, cap_edge, launch_edge;
    logic [1:0] prime;
    logic armed, fresh;
    spi_state_e state_q, state_d;
    logic do_load, do_shift, do_capture, go_idle, start;
    logic [CW-1:0] bit_cnt;
    logic last_bit;
    logic [DATA_WIDTH-2:0] rx_sr;
    logic [DATA_WIDTH-1:0] rx_next, tx_sr, buf_q;
    logic buf_full, accept;

    sync2 #(.RESET_VALUE(CPOL)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s));
    sync2 #(.RESET_VALUE(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(CS),   .q(cs_s));
    sync2 #(.RESET_VALUE(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s));

    assign sclk_change = sclk_s != sclk_q;
    assign lead_edge   = sclk_change && (sclk_s != CPOL);
    assign trail_edge  = sclk_change && (sclk_s == CPOL);
    assign cap_edge    = CPHA ? trail_edge : lead_edge;
    assign launch_edge = CPHA ? lead_edge : trail_edge;
    assign last_bit    = bit_cnt == CW'(DATA_WIDTH - 1);
    assign rx_next     = {rx_sr, mosi_s};
    assign accept      = tx_valid && (!buf_full || do_load);
    assign tx_ready    = !buf_full;
    assign busy        = !cs_s;

    // A transfer may start only after CS has been seen high once the synchroniser
    // holds real samples. Otherwise a CS that is still low at reset release would
    // look like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime  <= '0;
            armed  <= 1'b0;
            sclk_q <= CPOL;
        end else begin
            prime  <= {prime[0], 1'b1};
            armed  <= armed || (prime[1] && cs_s);
            sclk_q <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_capture = 1'b0;
        go_idle    = 1'b0;
        start      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed && !cs_s) begin
                    state_d = ST_ACTIVE;
                    start   = 1'b1;
                    do_load = !CPHA;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    go_idle = 1'b1;
                end else if (cap_edge) begin
                    do_capture = 1'b1;
                end else if (launch_edge) begin
                    if (bit_cnt == '0 && !(!CPHA && fresh)) do_load = 1'b1;
                    else                                    do_shift = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            fresh    <= 1'b0;
        end else begin
            rx_valid <= do_capture && last_bit;
            if (go_idle) begin
                bit_cnt <= '0;
            end else if (do_capture) begin
                rx_sr   <= rx_next[DATA_WIDTH-2:0];
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) rx_data <= rx_next;
            end
            if (start)                     fresh <= 1'b1;
            else if (do_load || do_shift) fresh <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr       <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            tx_underrun <= 1'b0;
            MISO        <= 1'b0;
        end else begin
            tx_underrun <= do_load && !buf_full;
            if (do_load)       tx_sr <= buf_full ? buf_q : UNDERRUN_WORD;
            else if (do_shift) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            if (accept) begin
                buf_q    <= tx_data;
                buf_full <= 1'b1;
            end else if (do_load) begin
                buf_full <= 1'b0;
            end
            MISO <= tx_sr[DATA_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave. One instance runs in each SPI mode. A master model drives each
// instance through table-driven single-word transfers and then through multi-word
// corner-case sequences.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sclk;
    logic [3:0] cs;
    logic       mosi;
    logic [3:0] miso;
    logic [7:0] tx_data [4];
    logic [3:0] tx_valid;
    logic [3:0] tx_ready;
    logic [7:0] rx_data [4];
    logic [3:0] rx_valid;
    logic [3:0] tx_underrun;
    logic [3:0] busy;

    int n_checks = 0;
    int n_pass   = 0;
    int rxv_cnt [4] = '{default: 0};
    int und_cnt [4] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic GPOL = (g / 2) == 1;
        localparam logic GPHA = (g % 2) == 1;
        spi_slave #(.DATA_WIDTH(8), .CPOL(GPOL), .CPHA(GPHA)) u_dut (
            .clk(clk), .rst_n(rst_n), .SCLK(sclk[g]), .CS(cs[g]), .MOSI(mosi),
            .MISO(miso[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .tx_underrun(tx_underrun[g]), .busy(busy[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i])    rxv_cnt[i]++;
            if (tx_underrun[i]) und_cnt[i]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_tx(input int m, input logic [7:0] w);
        tx_data[m]  = w;
        tx_valid[m] = 1'b1;
        tick(1);
        tx_valid[m] = 1'b0;
    endtask

    task automatic cs_low(input int m);
        cs[m] = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high(input int m);
        cs[m] = 1'b1;
        tick(HALF);
    endtask

    // Master side of one word. MISO is sampled just before each capture edge.
    task automatic xfer(input int m, input int nbits, input logic [7:0] mo,
                        input bit refill, input logic [7:0] rw, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = (m / 2) == 1;
        cpha = (m % 2) == 1;
        mi   = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mo[7-i];
                tick(HALF);
                mi = {mi[6:0], miso[m]};
                sclk[m] = ~cpol;
                tick(HALF);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = mo[7-i];
                tick(HALF);
                mi = {mi[6:0], miso[m]};
                sclk[m] = cpol;
                tick(HALF);
            end
            if (refill && i == 3) push_tx(m, rw);
        end
        tick(HALF);
    endtask

    typedef struct {
        int         mode;
        logic [7:0] tx_w;
        logic [7:0] mosi_w;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] got, got2;
        int r0, u0;

        vecs[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[2] = '{2, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[3] = '{3, 8'h0F, 8'hF0, 8'h0F, 8'hF0};
        vecs[4] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF};

        rst_n    = 1'b0;
        sclk     = 4'b1100;
        cs       = 4'hF;
        mosi     = 1'b0;
        tx_valid = '0;
        for (int i = 0; i < 4; i++) tx_data[i] = '0;
        tick(3);
        rst_n = 1'b1;
        tick(6);

        check("reset_miso", {28'd0, miso}, 32'h0);
        check("reset_tx_ready", {28'd0, tx_ready}, 32'hF);
        check("reset_busy", {28'd0, busy}, 32'h0);
        check("reset_rx_valid", {28'd0, rx_valid}, 32'h0);
        check("reset_underrun", {28'd0, tx_underrun}, 32'h0);
        check("reset_rx_data0", {24'd0, rx_data[0]}, 32'h0);

        // Single-word transfers with a preloaded transmit word
        for (int v = 0; v < 5; v++) begin
            push_tx(vecs[v].mode, vecs[v].tx_w);
            r0 = rxv_cnt[vecs[v].mode];
            cs_low(vecs[v].mode);
            check($sformatf("v%0d_busy", v), {31'd0, busy[vecs[v].mode]}, 32'h1);
            xfer(vecs[v].mode, 8, vecs[v].mosi_w, 1'b0, 8'h00, got);
            cs_high(vecs[v].mode);
            check($sformatf("v%0d_miso", v), {24'd0, got}, {24'd0, vecs[v].exp_miso});
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data[vecs[v].mode]}, {24'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_rx_valid_count", v), rxv_cnt[vecs[v].mode] - r0, 32'd1);
            check($sformatf("v%0d_tx_ready", v), {31'd0, tx_ready[vecs[v].mode]}, 32'h1);
        end

        // Two-word bursts with the buffer refilled mid-word (CPHA=0 also gets a
        // third word so that the closing launch edge has data)
        for (int m = 1; m < 4; m++) begin
            push_tx(m, 8'hC6 + 8'(m));
            r0 = rxv_cnt[m];
            u0 = und_cnt[m];
            cs_low(m);
            xfer(m, 8, 8'h96, 1'b1, 8'h39 + 8'(m), got);
            check($sformatf("burst%0d_rx_word1", m), {24'd0, rx_data[m]}, 32'h96);
            xfer(m, 8, 8'h4B, m == 2, 8'hEE, got2);
            cs_high(m);
            check($sformatf("burst%0d_miso1", m), {24'd0, got}, {24'd0, 8'hC6 + 8'(m)});
            check($sformatf("burst%0d_miso2", m), {24'd0, got2}, {24'd0, 8'h39 + 8'(m)});
            check($sformatf("burst%0d_rx_word2", m), {24'd0, rx_data[m]}, 32'h4B);
            check($sformatf("burst%0d_rx_valid_count", m), rxv_cnt[m] - r0, 32'd2);
            check($sformatf("burst%0d_underrun_count", m), und_cnt[m] - u0, 32'd0);
        end

        // Empty buffer on mode 1: underrun word is sent
        r0 = rxv_cnt[1];
        u0 = und_cnt[1];
        cs_low(1);
        xfer(1, 8, 8'h69, 1'b0, 8'h00, got);
        cs_high(1);
        check("underrun_miso", {24'd0, got}, 32'hFF);
        check("underrun_count", und_cnt[1] - u0, 32'd1);
        check("underrun_rx_data", {24'd0, rx_data[1]}, 32'h69);
        check("underrun_rx_valid_count", rxv_cnt[1] - r0, 32'd1);

        // CS aborted after 5 bits, then a full transfer sends the buffered word
        r0 = rxv_cnt[0];
        cs_low(0);
        xfer(0, 5, 8'h12, 1'b0, 8'h00, got);
        cs_high(0);
        check("abort_rx_valid_count", rxv_cnt[0] - r0, 32'd0);
        check("abort_rx_data_held", {24'd0, rx_data[0]}, 32'hFF);
        push_tx(0, 8'h5A);
        r0 = rxv_cnt[0];
        cs_low(0);
        xfer(0, 8, 8'hC3, 1'b0, 8'h00, got);
        cs_high(0);
        check("abort_next_miso", {24'd0, got}, 32'h5A);
        check("abort_next_rx_data", {24'd0, rx_data[0]}, 32'hC3);
        check("abort_next_rx_valid_count", rxv_cnt[0] - r0, 32'd1);

        // New word offered while the buffer drains at CS fall
        push_tx(0, 8'h81);
        check("same_cycle_ready_full", {31'd0, tx_ready[0]}, 32'h0);
        tx_data[0]  = 8'h7E;
        tx_valid[0] = 1'b1;
        u0 = und_cnt[0];
        cs[0] = 1'b0;
        tick(6);
        tx_valid[0] = 1'b0;
        check("same_cycle_ready_after_load", {31'd0, tx_ready[0]}, 32'h0);
        tick(HALF - 6);
        xfer(0, 8, 8'h11, 1'b0, 8'h00, got);
        check("same_cycle_ready_after_second_load", {31'd0, tx_ready[0]}, 32'h1);
        check("same_cycle_no_underrun", und_cnt[0] - u0, 32'd0);
        xfer(0, 8, 8'h22, 1'b0, 8'h00, got2);
        cs_high(0);
        check("same_cycle_miso1", {24'd0, got}, 32'h81);
        check("same_cycle_miso2", {24'd0, got2}, 32'h7E);

        // Reset mid-word with CS held low
        cs_low(0);
        push_tx(0, 8'h44);
        xfer(0, 4, 8'hF0, 1'b0, 8'h00, got);
        rst_n = 1'b0;
        tick(1);
        check("midreset_miso", {31'd0, miso[0]}, 32'h0);
        check("midreset_rx_data", {24'd0, rx_data[0]}, 32'h0);
        check("midreset_rx_valid", {31'd0, rx_valid[0]}, 32'h0);
        check("midreset_tx_ready", {31'd0, tx_ready[0]}, 32'h1);
        check("midreset_underrun", {31'd0, tx_underrun[0]}, 32'h0);
        check("midreset_busy", {31'd0, busy[0]}, 32'h0);
        rst_n = 1'b1;
        tick(4);
        r0 = rxv_cnt[0];
        xfer(0, 8, 8'hAA, 1'b0, 8'h00, got);
        check("postreset_ignored_rx_valid", rxv_cnt[0] - r0, 32'd0);
        check("postreset_ignored_rx_data", {24'd0, rx_data[0]}, 32'h0);
        cs_high(0);
        r0 = rxv_cnt[0];
        cs_low(0);
        xfer(0, 8, 8'h96, 1'b0, 8'h00, got);
        cs_high(0);
        check("postreset_miso", {24'd0, got}, 32'hFF);
        check("postreset_rx_data", {24'd0, rx_data[0]}, 32'h96);
        check("postreset_rx_valid_count", rxv_cnt[0] - r0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
